score_digits_renderer: RTL

//  Turns the binary game score into on-screen pixels. Converts score to BCD with a sequential

---
 rtl/score_digits_renderer_if.sv | 29 ++
 rtl/score_digits_renderer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/score_digits_renderer_if.sv
// Bus between the game/scan side and the score digit renderer: score load
// handshake, pixel scan in/out and the glyph ROM read port.
interface score_digits_renderer_if #(
  parameter int SCORE_W = 10,
  parameter int COORD_W = 11
);
  logic [SCORE_W-1:0] score;
  logic               score_valid;
  logic               busy;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               pixel_valid_in;
  logic [8:0]         rom_ad;
  logic               rom_dout;
  logic               pixel_valid_out;
  logic               pixel_on;

  // Environment side: game logic, pixel scanner and glyph ROM.
  modport master (
    output score, score_valid, x, y, pixel_valid_in, rom_dout,
    input  busy, rom_ad, pixel_valid_out, pixel_on
  );

  // Renderer side.
  modport slave (
    input  score, score_valid, x, y, pixel_valid_in, rom_dout,
    output busy, rom_ad, pixel_valid_out, pixel_on
  );
endinterface

// File: rtl/score_digits_renderer.sv
// Score digit renderer: sequential double-dabble binary-to-BCD conversion of
// the score, then a two-stage pixel pipeline that addresses the 5x9 glyph ROM
// and produces pixel_on for the scanned coordinate.
module score_digits_renderer #(
  parameter int DIGITS     = 3,
  parameter int SCORE_W    = 10,
  parameter int COORD_W    = 11,
  parameter int X_POS      = 8,
  parameter int Y_POS      = 8,
  parameter int SCALE_LOG2 = 1,
  parameter int SPACING    = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  score_digits_renderer_if.slave bus
);

  localparam int BCD_N  = DIGITS + 1;
  localparam int BCD_W  = 4 * BCD_N;
  localparam int DISP_W = 4 * DIGITS;
  localparam int CELL   = (5 + SPACING) << SCALE_LOG2;
  localparam int CNT_W  = $clog2(SCORE_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t             state_q;
  logic               busy_q;
  logic [DISP_W-1:0]  disp_q;
  logic               pend_vld_q;
  logic [SCORE_W-1:0] pend_score_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SCORE_W-1:0] work_q;
  logic [BCD_W-1:0]   bcd_q;

  logic               start_c;
  logic [SCORE_W-1:0] start_val_c;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_N; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Anything reaching the extra top nibble exceeds the display, so show all 9s.
  function automatic logic [DISP_W-1:0] sat_digits(input logic [BCD_W-1:0] v);
    if (v[BCD_W-1 -: 4] != 4'd0) return {DIGITS{4'd9}};
    return v[DISP_W-1:0];
  endfunction

  // A new conversion starts from IDLE on a strobe, or back-to-back out of
  // COMMIT with the freshest request (a same-cycle strobe beats the pending slot).
  always_comb begin
    start_c     = 1'b0;
    start_val_c = bus.score;
    if (state_q == S_IDLE) begin
      start_c = bus.score_valid;
    end else if (state_q == S_COMMIT) begin
      if (bus.score_valid) begin
        start_c = 1'b1;
      end else if (pend_vld_q) begin
        start_c     = 1'b1;
        start_val_c = pend_score_q;
      end
    end
  end

  // Conversion FSM and displayed digits; reset aborts any in-flight conversion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      disp_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_c) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SCORE_W - 1)) state_q <= S_COMMIT;
          if (bus.score_valid) pend_vld_q <= 1'b1;
        end
        S_COMMIT: begin
          disp_q     <= sat_digits(bcd_q);
          pend_vld_q <= 1'b0;
          cnt_q      <= '0;
          if (start_c) begin
            state_q <= S_SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Conversion datapath: load, correct-and-shift, and the latest pending score.
  always_ff @(posedge clk) begin
    if (start_c) begin
      work_q <= start_val_c;
      bcd_q  <= '0;
    end else if (state_q == S_SHIFT) begin
      {bcd_q, work_q} <= {add3(bcd_q), work_q} << 1;
    end
    if (bus.score_valid && state_q == S_SHIFT) pend_score_q <= bus.score;
  end

  logic [DIGITS-1:0] blank_c;
  logic              zero_run;

  // Leading-zero blanking, scanning from the leftmost digit; the last digit always draws.
  always_comb begin
    zero_run = 1'b1;
    blank_c  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      zero_run = zero_run & (disp_q[4*(DIGITS-1-k) +: 4] == 4'd0);
      if (k < DIGITS - 1) blank_c[k] = zero_run;
    end
  end

  logic [COORD_W-1:0] dx_c, dy_c, col_c, row_c;
  logic [3:0]         dig_c;
  logic               hit_c;
  logic [8:0]         ad_c;

  // Stage 0: locate the digit cell by constant compares, then glyph row/col and ROM address.
  always_comb begin
    dx_c  = bus.x - COORD_W'(X_POS);
    dy_c  = bus.y - COORD_W'(Y_POS);
    row_c = dy_c >> SCALE_LOG2;
    col_c = '0;
    dig_c = '0;
    hit_c = 1'b0;
    ad_c  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dx_c >= COORD_W'(k * CELL) && dx_c < COORD_W'((k + 1) * CELL)) begin
        col_c = (dx_c - COORD_W'(k * CELL)) >> SCALE_LOG2;
        dig_c = disp_q[4*(DIGITS-1-k) +: 4];
        hit_c = bus.pixel_valid_in && (bus.x >= COORD_W'(X_POS)) &&
                (bus.y >= COORD_W'(Y_POS)) && (col_c < COORD_W'(5)) &&
                (row_c < COORD_W'(9)) && !blank_c[k];
      end
    end
    if (hit_c) begin
      ad_c = ({5'd0, dig_c} * 9'd45) + ({5'd0, row_c[3:0]} * 9'd5) + {6'd0, col_c[2:0]};
    end
  end

  logic [8:0] rom_ad_p1;
  logic       hit_p1;
  logic       vld_p1;
  logic       on_p2;
  logic       vld_p2;

  // ---- stage 1: registered ROM address, hit flag and valid ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_ad_p1 <= '0;
      hit_p1    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      rom_ad_p1 <= ad_c;
      hit_p1    <= hit_c;
      vld_p1    <= bus.pixel_valid_in;
    end
  end

  // ---- stage 2: gate ROM bit with hit, register pixel output ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      on_p2  <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      on_p2  <= hit_p1 & bus.rom_dout;
      vld_p2 <= vld_p1;
    end
  end

  assign bus.rom_ad          = rom_ad_p1;
  assign bus.pixel_on        = on_p2;
  assign bus.pixel_valid_out = vld_p2;
  assign bus.busy            = busy_q;

endmodule
